// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM states and synchronizer depth
// for the SPI flash responder.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_responder_sync_edge.sv
// Two-flop synchronizer with an extra history flop
// for rising/falling edge detection.
module spi_sync_edge
  import spi_flash_responder_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ (0x03) and JEDEC-ID (0x9F)
// served from a synchronous byte-wide memory port.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          MEM_ADDR_W = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise_unused, cs_fall_unused;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk_i  (pclk),
    .rst_i  (preset),
    .d_i    (spi_clk),
    .sync_o (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // cs resets to the deselected level so reset never looks like a select
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i  (pclk),
    .rst_i  (preset),
    .d_i    (spi_cs),
    .sync_o (cs_s),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall_unused)
  );

  always_ff @(posedge pclk) begin
    if (preset) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_e                state_q;
  logic [4:0]            bit_q;
  logic [22:0]           rx_q;
  logic [MEM_ADDR_W-1:0] addr_q, maddr_q;
  logic [7:0]            tx_q, hold_q;
  logic [1:0]            idx_q;
  logic                  miso_q, req_q, rvalid_q;

  logic [23:0]           rx_d;
  logic [MEM_ADDR_W-1:0] addr_d;
  logic [7:0]            id_byte_d;

  assign rx_d   = {rx_q, mosi_s};
  assign addr_d = addr_q + MEM_ADDR_W'(1);

  always_comb begin
    id_byte_d = 8'h00;
    unique case (idx_q)
      2'd1:    id_byte_d = JEDEC_ID[15:8];
      2'd2:    id_byte_d = JEDEC_ID[7:0];
      default: id_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      rx_q     <= '0;
      addr_q   <= '0;
      maddr_q  <= '0;
      tx_q     <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
      miso_q   <= 1'b0;
      req_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      req_q    <= 1'b0;
      rvalid_q <= req_q;
      if (cs_s) begin
        // deselect beats any edge seen this cycle
        state_q  <= ST_IDLE;
        bit_q    <= '0;
        rx_q     <= '0;
        idx_q    <= '0;
        miso_q   <= 1'b0;
        rvalid_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_CMD;
            bit_q   <= '0;
          end
          ST_CMD: if (sck_rise) begin
            rx_q  <= rx_d[22:0];
            bit_q <= bit_q + 5'd1;
            if (bit_q == 5'd7) begin
              bit_q <= '0;
              unique case (1'b1)
                (rx_d[7:0] == CMD_READ): state_q <= ST_ADDR;
                (rx_d[7:0] == CMD_RDID): begin
                  state_q <= ST_ID;
                  tx_q    <= JEDEC_ID[23:16];
                  idx_q   <= 2'd1;
                end
                default: state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              rx_q  <= rx_d[22:0];
              bit_q <= bit_q + 5'd1;
              if (bit_q == 5'd23) begin
                bit_q   <= '0;
                addr_q  <= rx_d[MEM_ADDR_W-1:0];
                maddr_q <= rx_d[MEM_ADDR_W-1:0];
                req_q   <= 1'b1;
              end
            end else if (rvalid_q) begin
              tx_q    <= mem_rdata;
              state_q <= ST_DATA;
            end
          end
          ST_DATA, ST_ID: begin
            if (state_q == ST_DATA && rvalid_q) hold_q <= mem_rdata;
            if (sck_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
              bit_q  <= bit_q + 5'd1;
              // bit7 just left: fetch the next byte into the holding reg
              if (bit_q == 5'd0 && state_q == ST_DATA) begin
                addr_q  <= addr_d;
                maddr_q <= addr_d;
                req_q   <= 1'b1;
              end
              if (bit_q == 5'd7) begin
                bit_q <= '0;
                if (state_q == ST_DATA) begin
                  tx_q <= hold_q;
                end else begin
                  tx_q <= id_byte_d;
                  if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
                end
              end
            end
          end
          ST_IGNORE: miso_q <= 1'b0;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso = miso_q;
  assign mem_req  = req_q;
  assign mem_addr = maddr_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 24-bit and an 8-bit
// address instance share one SPI bus, each with its own memory.
module tb_spi_flash_responder;

  logic pclk = 1'b0;
  logic preset, spi_clk, spi_cs, spi_mosi;

  logic        miso_a, req_a, busy_a;
  logic [23:0] addr_a;
  logic [7:0]  rdata_a = 8'h00;
  logic        miso_b, req_b, busy_b;
  logic [7:0]  addr_b;
  logic [7:0]  rdata_b = 8'h00;

  int vectors = 0;
  int errors  = 0;

  bit zero_chk, req_ok;
  bit prev_a = 1'b0, prev_b = 1'b0;
  logic [23:0] qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  got_a[16];
  logic [7:0]  got_b[16];

  always #5 pclk = ~pclk;

  spi_flash_responder dut_a (
    .pclk      (pclk),
    .preset    (preset),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (miso_a),
    .mem_req   (req_a),
    .mem_addr  (addr_a),
    .mem_rdata (rdata_a),
    .busy      (busy_a)
  );

  spi_flash_responder #(.MEM_ADDR_W(8)) dut_b (
    .pclk      (pclk),
    .preset    (preset),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (miso_b),
    .mem_req   (req_b),
    .mem_addr  (addr_b),
    .mem_rdata (rdata_b),
    .busy      (busy_b)
  );

  // memory: data is low address byte xor 0x5A, one cycle latency
  always @(posedge pclk) begin
    if (req_a) rdata_a <= addr_a[7:0] ^ 8'h5A;
    if (req_b) rdata_b <= addr_b ^ 8'h5A;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_addr(input logic [23:0] a,
                                           input int k,
                                           input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (a + 24'(k)) & m[23:0];
  endfunction

  function automatic logic [7:0] exp_byte(input bit rd, input bit id,
                                          input logic [23:0] a,
                                          input int k);
    logic [23:0] jd;
    logic [23:0] ea;
    jd = 24'hEF4018;
    if (id) return (k < 3) ? jd[23-8*k -: 8] : 8'h00;
    if (!rd) return 8'h00;
    ea = a + 24'(k);
    return ea[7:0] ^ 8'h5A;
  endfunction

  // per-cycle checks on both instances
  always @(negedge pclk) begin
    if (req_a) qa.push_back(addr_a);
    if (req_b) qb.push_back(addr_b);
    if (zero_chk) begin
      check("miso_a_zero", {31'd0, miso_a}, 32'd0);
      check("miso_b_zero", {31'd0, miso_b}, 32'd0);
    end
    if (!req_ok) begin
      check("req_a_quiet", {31'd0, req_a}, 32'd0);
      check("req_b_quiet", {31'd0, req_b}, 32'd0);
    end
    if (req_a) check("req_a_b2b", {31'd0, prev_a}, 32'd0);
    if (req_b) check("req_b_b2b", {31'd0, prev_b}, 32'd0);
    if (preset) begin
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    end
    prev_a = req_a;
    prev_b = req_b;
  end

  task automatic sck_cycle(input bit mo, output bit ma, output bit mb);
    spi_clk  = 1'b0;
    spi_mosi = mo;
    repeat (4) @(posedge pclk);
    #1;
    ma = miso_a;
    mb = miso_b;
    spi_clk = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] a,
                      input int abits, input int nbytes,
                      input string tag);
    bit is_read, is_id, ma, mb, ok;
    logic [7:0] ba, bb;
    int hi;
    is_read = (cmd == 8'h03) && (abits == 24);
    is_id   = (cmd == 8'h9F);
    qa.delete();
    qb.delete();
    req_ok = is_read;
    spi_cs = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    for (int i = 7; i >= 0; i--) sck_cycle(cmd[i], ma, mb);
    for (int i = 0; i < abits; i++) sck_cycle(a[23-i], ma, mb);
    if (is_read || is_id) begin
      zero_chk = 1'b0;
      check({tag, "_busy"}, {31'd0, busy_a & busy_b}, 32'd1);
    end
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 7; i >= 0; i--) begin
        sck_cycle(1'b0, ma, mb);
        ba[i] = ma;
        bb[i] = mb;
      end
      got_a[k] = ba;
      got_b[k] = bb;
      check($sformatf("%s_a_byte%0d", tag, k), {24'd0, ba},
            {24'd0, exp_byte(is_read, is_id, a, k)});
      check($sformatf("%s_b_byte%0d", tag, k), {24'd0, bb},
            {24'd0, exp_byte(is_read, is_id, a, k)});
    end
    spi_cs = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    spi_clk = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
    zero_chk = 1'b1;
    req_ok   = 1'b0;
    check({tag, "_idle_a"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_idle_b"}, {31'd0, busy_b}, 32'd0);
    // one read per byte, plus at most one prefetch
    hi = is_read ? nbytes + 1 : 0;
    ok = (qa.size() >= (is_read ? nbytes : 0)) && (qa.size() <= hi);
    check({tag, "_nreq_a"}, {31'd0, ok}, 32'd1);
    ok = (qb.size() >= (is_read ? nbytes : 0)) && (qb.size() <= hi);
    check({tag, "_nreq_b"}, {31'd0, ok}, 32'd1);
    for (int k = 0; k < qa.size() && k <= hi; k++)
      check($sformatf("%s_addr_a%0d", tag, k), {8'd0, qa[k]},
            {8'd0, exp_addr(a, k, 24)});
    for (int k = 0; k < qb.size() && k <= hi; k++)
      check($sformatf("%s_addr_b%0d", tag, k), {24'd0, qb[k]},
            {8'd0, exp_addr(a, k, 8)});
  endtask

  initial begin
    logic [7:0] lit_rd[4];
    logic [7:0] lit_id[4];
    logic [7:0] lit_wr[3];
    lit_rd = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    lit_id = '{8'hEF, 8'h40, 8'h18, 8'h00};
    lit_wr = '{8'hFE, 8'hFF, 8'h00};

    preset   = 1'b1;
    spi_cs   = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    zero_chk = 1'b1;
    req_ok   = 1'b0;
    repeat (3) begin
      @(posedge pclk);
      #1;
      spi_clk = ~spi_clk;
    end
    preset = 1'b0;
    for (int i = 0; i < 3 && !(busy_a && busy_b); i++) begin
      @(posedge pclk);
      #1;
    end
    check("busy_rise_a", {31'd0, busy_a}, 32'd1);
    check("busy_rise_b", {31'd0, busy_b}, 32'd1);
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
    check("desel_a", {31'd0, busy_a}, 32'd0);
    check("desel_b", {31'd0, busy_b}, 32'd0);

    xfer(8'h03, 24'h000100, 24, 4, "rd100");
    for (int k = 0; k < 4; k++)
      check($sformatf("rd100_lit%0d", k), {24'd0, got_a[k]},
            {24'd0, lit_rd[k]});

    xfer(8'h03, 24'h0000FE, 24, 3, "wrap");
    for (int k = 0; k < 3; k++)
      check($sformatf("wrap_lit%0d", k), {24'd0, qb[k]},
            {24'd0, lit_wr[k]});

    xfer(8'h9F, 24'h000000, 0, 4, "jedec");
    for (int k = 0; k < 4; k++)
      check($sformatf("jedec_lit%0d", k), {24'd0, got_a[k]},
            {24'd0, lit_id[k]});

    xfer(8'hAB, 24'h000000, 0, 2, "ignore");
    xfer(8'h03, 24'h000020, 24, 2, "rd020");
    check("rd020_lit", {24'd0, got_b[1]}, 32'h7B);

    xfer(8'h03, 24'hC3A5F0, 12, 0, "abort");
    xfer(8'h03, 24'h000010, 24, 2, "rd010");
    check("rd010_lit", {24'd0, got_a[0]}, 32'h4A);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
